// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART blocks. It contains:
//   - the receiver FSM state encoding
//   - a parity helper
//   - a counter-width helper used to size the baud and idle counters
// Payloads of up to 16 bits are supported by the parity helper.
// -----------------------------------------------------------------------------
package uart_pkg;

   typedef logic [2:0] rx_state_t;

   localparam rx_state_t RX_IDLE   = 3'd0;
   localparam rx_state_t RX_START  = 3'd1;
   localparam rx_state_t RX_DATA   = 3'd2;
   localparam rx_state_t RX_PARITY = 3'd3;
   localparam rx_state_t RX_STOP   = 3'd4;
   localparam rx_state_t RX_BREAK  = 3'd5;

   // Width of a counter that must hold values 0..n-1 (at least one bit).
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n <= 32'd1) ? 32'd1 : $clog2(n);
   endfunction

   // Parity error flag: returns 1 when data plus the received parity bit
   // do not give the configured sense (odd = 0 for even, 1 for odd).
   function automatic logic parity_err(input logic [15:0] data,
                                       input logic        par_bit,
                                       input logic        odd);
      return (^data) ^ par_bit ^ odd;
   endfunction

endpackage

// File: rtl/axis_sync_fifo.sv
// -----------------------------------------------------------------------------
// axis_sync_fifo
// Small synchronous FIFO with an AXI-Stream style read side.
// Ports:
//   clk, rst  clock and synchronous active-high reset
//   push_i    write request
//   data_i    write data
//   pop_i     downstream ready
//   data_o    head entry
//   valid_o   head valid
//   drop_o    push rejected because the FIFO was full and not popping
// A push into a full FIFO is accepted only when a pop happens in the same
// cycle. There is no bypass path: a push into an empty FIFO becomes visible
// on the cycle after the write.
// -----------------------------------------------------------------------------
module axis_sync_fifo
   import uart_pkg::*;
#(
   parameter int unsigned WIDTH = 10,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] data_o,
   output logic             valid_o,
   output logic             drop_o
);

   localparam int unsigned PTR_W = cnt_width(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             valid_q, valid_d;
   logic             pop_s, push_ok_s, full_s;

   // Handshake qualification and next-state pointer/count computation.
   always_comb begin
      full_s    = (count_q == CNT_FULL);
      pop_s     = pop_i && valid_q;
      push_ok_s = push_i && (!full_s || pop_s);
      drop_o    = push_i && !push_ok_s;
      wr_ptr_d  = push_ok_s ? (wr_ptr_q + 1'b1) : wr_ptr_q;
      rd_ptr_d  = pop_s ? (rd_ptr_q + 1'b1) : rd_ptr_q;
      case ({push_ok_s, pop_s})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
      valid_d = (count_d != '0);
   end

   // Storage, pointers and occupancy registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         valid_q  <= 1'b0;
      end else begin
         if (push_ok_s) begin
            mem_q[wr_ptr_q] <= data_i;
         end
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         valid_q  <= valid_d;
      end
   end

   assign data_o  = mem_q[rd_ptr_q];
   assign valid_o = valid_q;

endmodule

// File: rtl/uart_rx_axis.sv
// -----------------------------------------------------------------------------
// uart_rx_axis
// UART receiver that delivers bytes on an AXI4-Stream master port.
// Ports:
//   clk, rst       clock and synchronous active-high reset
//   uart_rx        asynchronous serial line (idle high)
//   m_axis_*       byte stream:
//                    tdata = byte
//                    tlast = idle gap followed this byte
//                    tuser = parity error
//   frame_err      one-cycle pulse when a stop bit is sampled low (byte dropped)
//   overrun        one-cycle pulse when a byte is dropped because the FIFO is full
// Each good byte waits in a hold register until one of two events decides
// whether it ends a burst:
//   - the next start bit is confirmed: the byte is pushed with tlast = 0
//   - the line stays idle for IDLE_BITS bit-times: the byte is pushed with
//     tlast = 1
// -----------------------------------------------------------------------------
module uart_rx_axis
   import uart_pkg::*;
#(
   parameter int unsigned DATA_BITS    = 8,
   parameter int unsigned CLKS_PER_BIT = 434,
   parameter int unsigned PARITY_EN    = 1,
   parameter int unsigned PARITY_ODD   = 0,
   parameter int unsigned FIFO_DEPTH   = 4,
   parameter int unsigned IDLE_BITS    = 20
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 uart_rx,
   output logic [DATA_BITS-1:0] m_axis_tdata,
   output logic                 m_axis_tvalid,
   input  logic                 m_axis_tready,
   output logic                 m_axis_tlast,
   output logic                 m_axis_tuser,
   output logic                 frame_err,
   output logic                 overrun
);

   localparam int unsigned BAUD_W      = cnt_width(CLKS_PER_BIT);
   localparam int unsigned IDLE_CYCLES = IDLE_BITS * CLKS_PER_BIT;
   localparam int unsigned IDLE_W      = cnt_width(IDLE_CYCLES);
   localparam int unsigned BIT_W       = cnt_width(DATA_BITS);
   localparam int unsigned ENTRY_W     = DATA_BITS + 2;

   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [BAUD_W-1:0] HALF_LAST = BAUD_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_CYCLES - 1);
   localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);
   localparam logic              PAR_ON    = (PARITY_EN != 0);
   localparam logic              PAR_ODD   = (PARITY_ODD != 0);

   logic                 sync1_q, sync2_q;
   logic [1:0]           settle_q;
   logic                 armed_q, armed_d;
   rx_state_t            state_q, state_d;
   logic [BAUD_W-1:0]    baud_q, baud_d;
   logic [BIT_W-1:0]     bit_q, bit_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 perr_q, perr_d;
   logic                 hold_valid_q, hold_valid_d;
   logic [DATA_BITS-1:0] hold_data_q, hold_data_d;
   logic                 hold_perr_q, hold_perr_d;
   logic [IDLE_W-1:0]    idle_q, idle_d;
   logic                 frame_err_q, frame_err_d;
   logic                 overrun_q;

   logic                 rx_s;
   logic                 start_ok_s, capture_s, stop_exit_s;
   logic                 push_s, push_last_s;
   logic [ENTRY_W-1:0]   push_data_s, fifo_data_s;
   logic                 fifo_valid_s, drop_s;

   assign rx_s = sync2_q;

   // Frame FSM, hold register and idle-gap timer.
   always_comb begin
      state_d      = state_q;
      baud_d       = baud_q;
      bit_d        = bit_q;
      shift_d      = shift_q;
      perr_d       = perr_q;
      hold_valid_d = hold_valid_q;
      hold_data_d  = hold_data_q;
      hold_perr_d  = hold_perr_q;
      frame_err_d  = 1'b0;
      start_ok_s   = 1'b0;
      capture_s    = 1'b0;
      stop_exit_s  = 1'b0;
      push_s       = 1'b0;
      push_last_s  = 1'b0;

      // The settle bits keep the reset value of the synchroniser from arming
      // the receiver: only a real high sample of the line counts.
      armed_d = armed_q | (settle_q[1] & rx_s);

      case (state_q)
         RX_IDLE: begin
            // The line is always high on entry to IDLE, so low here is a falling edge.
            if (armed_q && !rx_s) begin
               state_d = RX_START;
               baud_d  = '0;
            end else begin
               state_d = RX_IDLE;
            end
         end
         RX_START: begin
            if (baud_q == HALF_LAST) begin
               baud_d = '0;
               if (!rx_s) begin
                  state_d    = RX_DATA;
                  bit_d      = '0;
                  perr_d     = 1'b0;
                  start_ok_s = 1'b1;
               end else begin
                  state_d = RX_IDLE;
               end
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         RX_DATA: begin
            if (baud_q == BAUD_LAST) begin
               baud_d  = '0;
               shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
               if (bit_q == BIT_LAST) begin
                  state_d = PAR_ON ? RX_PARITY : RX_STOP;
               end else begin
                  bit_d = bit_q + 1'b1;
               end
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         RX_PARITY: begin
            if (baud_q == BAUD_LAST) begin
               baud_d  = '0;
               perr_d  = parity_err(16'(shift_q), rx_s, PAR_ODD);
               state_d = RX_STOP;
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         RX_STOP: begin
            if (baud_q == BAUD_LAST) begin
               baud_d      = '0;
               stop_exit_s = 1'b1;
               if (rx_s) begin
                  capture_s = 1'b1;
                  state_d   = RX_IDLE;
               end else begin
                  frame_err_d = 1'b1;
                  state_d     = RX_BREAK;
               end
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         RX_BREAK: begin
            if (rx_s) begin
               state_d = RX_IDLE;
            end else begin
               state_d = RX_BREAK;
            end
         end
         default: begin
            state_d = RX_IDLE;
         end
      endcase

      // A confirmed start takes priority over the idle timeout; either one
      // releases the held byte.
      if (hold_valid_q && start_ok_s) begin
         push_s       = 1'b1;
         push_last_s  = 1'b0;
         hold_valid_d = 1'b0;
      end else if (hold_valid_q && (idle_q == IDLE_LAST)) begin
         push_s       = 1'b1;
         push_last_s  = 1'b1;
         hold_valid_d = 1'b0;
      end else begin
         push_s      = 1'b0;
         push_last_s = 1'b0;
      end

      if (capture_s) begin
         hold_valid_d = 1'b1;
         hold_data_d  = shift_q;
         hold_perr_d  = PAR_ON ? perr_q : 1'b0;
      end else begin
         hold_data_d = hold_data_q;
      end

      // The idle timer restarts at every stop-bit exit, including a framing error.
      if (stop_exit_s || !hold_valid_q) begin
         idle_d = '0;
      end else begin
         idle_d = idle_q + 1'b1;
      end
   end

   assign push_data_s = {hold_perr_q, push_last_s, hold_data_q};

   // Synchroniser, FSM state and status pulse registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q      <= 1'b1;
         sync2_q      <= 1'b1;
         settle_q     <= 2'b00;
         armed_q      <= 1'b0;
         state_q      <= RX_IDLE;
         baud_q       <= '0;
         bit_q        <= '0;
         shift_q      <= '0;
         perr_q       <= 1'b0;
         hold_valid_q <= 1'b0;
         hold_data_q  <= '0;
         hold_perr_q  <= 1'b0;
         idle_q       <= '0;
         frame_err_q  <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         sync1_q      <= uart_rx;
         sync2_q      <= sync1_q;
         settle_q     <= {settle_q[0], 1'b1};
         armed_q      <= armed_d;
         state_q      <= state_d;
         baud_q       <= baud_d;
         bit_q        <= bit_d;
         shift_q      <= shift_d;
         perr_q       <= perr_d;
         hold_valid_q <= hold_valid_d;
         hold_data_q  <= hold_data_d;
         hold_perr_q  <= hold_perr_d;
         idle_q       <= idle_d;
         frame_err_q  <= frame_err_d;
         overrun_q    <= drop_s;
      end
   end

   axis_sync_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push_s),
      .data_i  (push_data_s),
      .pop_i   (m_axis_tready),
      .data_o  (fifo_data_s),
      .valid_o (fifo_valid_s),
      .drop_o  (drop_s)
   );

   assign m_axis_tdata  = fifo_data_s[DATA_BITS-1:0];
   assign m_axis_tlast  = fifo_data_s[DATA_BITS];
   assign m_axis_tuser  = fifo_data_s[DATA_BITS+1];
   assign m_axis_tvalid = fifo_valid_s;
   assign frame_err     = frame_err_q;
   assign overrun       = overrun_q;

endmodule

// File: tb/tb_uart_rx_axis.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_axis
// Directed bench for uart_rx_axis with a small bit period (16 clocks), a
// 20 bit-time idle gap, a 4-entry FIFO and even parity.
// Every driven frame that should produce a beat pushes {tuser,tlast,tdata}
// into a scoreboard queue. Each accepted beat pops and compares one entry.
// -----------------------------------------------------------------------------
module tb_uart_rx_axis;

   localparam int CPB = 16;

   logic       clk = 1'b0;
   logic       rst;
   logic       uart_rx;
   logic [7:0] m_axis_tdata;
   logic       m_axis_tvalid;
   logic       m_axis_tready;
   logic       m_axis_tlast;
   logic       m_axis_tuser;
   logic       frame_err;
   logic       overrun;

   int checks   = 0;
   int errors   = 0;
   int beat_cnt = 0;
   int fe_cnt   = 0;
   int ov_cnt   = 0;

   logic [9:0] exp_q [$];

   always #5 clk = ~clk;

   uart_rx_axis #(
      .DATA_BITS    (8),
      .CLKS_PER_BIT (CPB),
      .PARITY_EN    (1),
      .PARITY_ODD   (0),
      .FIFO_DEPTH   (4),
      .IDLE_BITS    (20)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .uart_rx       (uart_rx),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .m_axis_tlast  (m_axis_tlast),
      .m_axis_tuser  (m_axis_tuser),
      .frame_err     (frame_err),
      .overrun       (overrun)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Runs once per cycle at the falling edge; a beat counts as accepted when
   // valid and ready are both high ahead of the next rising edge.
   task automatic monitor();
      logic [9:0] got;
      logic [9:0] e;
      if (frame_err === 1'b1) fe_cnt++;
      if (overrun === 1'b1) ov_cnt++;
      if (m_axis_tvalid === 1'b1 && m_axis_tready === 1'b1) begin
         beat_cnt++;
         got = {m_axis_tuser, m_axis_tlast, m_axis_tdata};
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("beat", 32'(got), 32'(e));
         end else begin
            chk("extra_beat", 32'(exp_q.size()), 32'd1);
         end
      end
   endtask

   task automatic tick();
      @(negedge clk);
      monitor();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic send_bit(input logic b);
      uart_rx = b;
      ticks(CPB);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(d[i]);
      send_bit(par);
      send_bit(stop);
      uart_rx = 1'b1;
   endtask

   task automatic expect_beat(input logic [7:0] d, input logic user, input logic last);
      exp_q.push_back({user, last, d});
   endtask

   function automatic logic even_par(input logic [7:0] d);
      return ^d;
   endfunction

   initial begin
      int b0;
      int fe0;
      int ov0;
      logic [7:0] d;

      // Reset values.
      rst = 1'b1;
      uart_rx = 1'b1;
      m_axis_tready = 1'b1;
      ticks(4);
      chk("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
      chk("rst_tdata", 32'(m_axis_tdata), 32'd0);
      chk("rst_tlast", 32'(m_axis_tlast), 32'd0);
      chk("rst_tuser", 32'(m_axis_tuser), 32'd0);
      chk("rst_frame_err", 32'(frame_err), 32'd0);
      chk("rst_overrun", 32'(overrun), 32'd0);
      rst = 1'b0;
      ticks(5);

      // Single byte, closed by the idle gap.
      expect_beat(8'hA5, 1'b0, 1'b1);
      send_frame(8'hA5, even_par(8'hA5), 1'b1);
      ticks(300);
      chk("a5_not_before_gap", 32'(m_axis_tvalid), 32'd0);
      ticks(100);
      chk("a5_drained", 32'(exp_q.size()), 32'd0);
      chk("a5_beats", 32'(beat_cnt), 32'd1);

      // Back-to-back burst: only the last byte carries tlast.
      expect_beat(8'h01, 1'b0, 1'b0);
      expect_beat(8'h02, 1'b0, 1'b0);
      expect_beat(8'h03, 1'b0, 1'b1);
      send_frame(8'h01, even_par(8'h01), 1'b1);
      send_frame(8'h02, even_par(8'h02), 1'b1);
      send_frame(8'h03, even_par(8'h03), 1'b1);
      ticks(400);
      chk("burst_drained", 32'(exp_q.size()), 32'd0);
      chk("burst_beats", 32'(beat_cnt), 32'd4);

      // Wrong parity bit: tuser set, no framing error.
      fe0 = fe_cnt;
      expect_beat(8'h07, 1'b1, 1'b1);
      send_frame(8'h07, 1'b0, 1'b1);
      ticks(400);
      chk("perr_drained", 32'(exp_q.size()), 32'd0);
      chk("perr_no_frame_err", 32'(fe_cnt), 32'(fe0));

      // Stop bit low: one frame_err cycle, no beat; the next byte is received.
      b0 = beat_cnt;
      send_frame(8'h55, even_par(8'h55), 1'b0);
      ticks(30);
      chk("ferr_pulse_cycles", 32'(fe_cnt), 32'(fe0 + 1));
      chk("ferr_no_beat", 32'(beat_cnt), 32'(b0));
      expect_beat(8'h66, 1'b0, 1'b1);
      send_frame(8'h66, even_par(8'h66), 1'b1);
      ticks(400);
      chk("after_ferr_drained", 32'(exp_q.size()), 32'd0);

      // Stalled sink: six single-byte bursts; the first four stay in the FIFO.
      m_axis_tready = 1'b0;
      ov0 = ov_cnt;
      for (int i = 0; i < 6; i++) begin
         d = 8'h10 + 8'(i);
         if (i < 4) expect_beat(d, 1'b0, 1'b1);
         send_frame(d, even_par(d), 1'b1);
         ticks(400);
      end
      chk("stall_tvalid", 32'(m_axis_tvalid), 32'd1);
      chk("stall_head_tdata", 32'(m_axis_tdata), 32'h10);
      chk("stall_head_tlast", 32'(m_axis_tlast), 32'd1);
      chk("overrun_cycles", 32'(ov_cnt), 32'(ov0 + 2));
      m_axis_tready = 1'b1;
      ticks(20);
      chk("stall_drained", 32'(exp_q.size()), 32'd0);
      chk("stall_empty", 32'(m_axis_tvalid), 32'd0);

      // Short low glitch on an idle line is rejected.
      b0 = beat_cnt;
      uart_rx = 1'b0;
      ticks(4);
      uart_rx = 1'b1;
      ticks(400);
      chk("glitch_no_beat", 32'(beat_cnt), 32'(b0));

      // Reset mid-DATA discards the FIFO contents and the frame in progress.
      m_axis_tready = 1'b0;
      fe0 = fe_cnt;
      send_frame(8'h77, even_par(8'h77), 1'b1);
      ticks(20);
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      chk("pre_reset_valid", 32'(m_axis_tvalid), 32'd1);
      rst = 1'b1;
      uart_rx = 1'b1;
      ticks(2);
      rst = 1'b0;
      tick();
      chk("midrst_tvalid", 32'(m_axis_tvalid), 32'd0);
      chk("midrst_tdata", 32'(m_axis_tdata), 32'd0);
      chk("midrst_tlast", 32'(m_axis_tlast), 32'd0);
      chk("midrst_tuser", 32'(m_axis_tuser), 32'd0);
      m_axis_tready = 1'b1;
      ticks(400);
      chk("midrst_no_beat", 32'(beat_cnt), 32'(b0));
      chk("midrst_no_frame_err", 32'(fe_cnt), 32'(fe0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
